// File: rtl/mxv_seq_nnbit_jkdim_act_if.sv
// Job handshake and operand/result bus for the sequential fully-connected layer core.
// The master drives the operands and start; the slave returns busy/done and the packed results.
interface mxv_seq_nnbit_jkdim_act_if #(
    parameter int N = 8,
    parameter int J = 3,
    parameter int K = 3
);
    localparam int L = 2 * N + $clog2(K);

    logic               start;
    logic [J*K*N-1:0]   g_input;
    logic [K*N-1:0]     e_input;
    logic               busy;
    logic               done;
    logic [J*L-1:0]     o;

    modport master (
        output start, g_input, e_input,
        input  busy, done, o
    );

    modport slave (
        input  start, g_input, e_input,
        output busy, done, o
    );
endinterface

// File: rtl/mxv_seq_nnbit_jkdim_act.sv
// Sequential R = act(W*X) core: one signed MAC per clock, J*K cycles per job, registered results.
// Define FC_RELU_EN to clamp every result row at zero; otherwise raw signed sums are output.
//
// state  | meaning
// S_IDLE | waiting for start; operands latched on acceptance
// S_RUN  | one MAC per cycle over (j,k); row j written at k==K-1
// S_DONE | single-cycle done pulse, start ignored
module mxv_seq_nnbit_jkdim_act #(
    parameter int N = 8,
    parameter int J = 3,
    parameter int K = 3
) (
    input  logic clk,
    input  logic rst,
    mxv_seq_nnbit_jkdim_act_if.slave bus
);
    localparam int L  = 2 * N + $clog2(K);
    localparam int PW = 2 * N;
    localparam int JW = (J > 1) ? $clog2(J) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int WW = (J * K > 1) ? $clog2(J * K) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(J - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_load;

    logic signed [N-1:0] r_w [J*K];
    logic signed [N-1:0] r_x [K];
    logic signed [L-1:0] r_acc;
    logic signed [L-1:0] r_o [J];
    logic [JW-1:0]       r_j;
    logic [KW-1:0]       r_k;
    logic [WW-1:0]       r_wi;

    logic signed [PW-1:0] w_w_ext;
    logic signed [PW-1:0] w_x_ext;
    logic signed [PW-1:0] w_prod;
    logic signed [L-1:0]  w_prod_ext;
    logic signed [L-1:0]  w_acc_nxt;
    logic signed [L-1:0]  w_act;
    logic                 w_row_end;
    logic                 w_last_row;

    // The 2N-bit product is exact: the largest magnitude is 2^(2N-2).
    assign w_w_ext    = PW'(r_w[r_wi]);
    assign w_x_ext    = PW'(r_x[r_k]);
    assign w_prod     = w_w_ext * w_x_ext;
    assign w_prod_ext = L'(w_prod);
    assign w_acc_nxt  = r_acc + w_prod_ext;
    assign w_row_end  = (r_k == K_LAST);
    assign w_last_row = (r_j == J_LAST);

`ifdef FC_RELU_EN
    assign w_act = w_acc_nxt[L-1] ? '0 : w_acc_nxt;
`else
    assign w_act = w_acc_nxt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_row_end && w_last_row) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand snapshot, accumulator, indices and result rows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < J * K; i++) begin
                r_w[i] <= '0;
            end
            for (int i = 0; i < K; i++) begin
                r_x[i] <= '0;
            end
            for (int i = 0; i < J; i++) begin
                r_o[i] <= '0;
            end
            r_acc <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_wi  <= '0;
        end else if (w_load) begin
            for (int i = 0; i < J * K; i++) begin
                r_w[i] <= bus.g_input[i*N +: N];
            end
            for (int i = 0; i < K; i++) begin
                r_x[i] <= bus.e_input[i*N +: N];
            end
            r_acc <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_wi  <= '0;
        end else if (r_state == S_RUN) begin
            r_wi <= r_wi + 1'b1;
            if (w_row_end) begin
                r_o[r_j] <= w_act;
                r_acc    <= '0;
                r_k      <= '0;
                if (!w_last_row) begin
                    r_j <= r_j + 1'b1;
                end
            end else begin
                r_acc <= w_acc_nxt;
                r_k   <= r_k + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < J; g++) begin : g_out
        assign bus.o[g*L +: L] = r_o[g];
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
endmodule
